// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates IF/LSB onto the byte-wide RAM/IO port and serialises 1/2/4-byte accesses.
// Optional IO_STALL_EN: stores to the UART addresses wait while io_buffer_full is high.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  clear_signal,
    input  logic                  if_signal,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [REG_WIDTH-1:0]  if_data,
    output logic                  if_done,
    input  logic                  lsb_signal,
    input  logic                  lsb_wr,
    input  logic [1:0]            lsb_len,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [REG_WIDTH-1:0]  lsb_dout,
    output logic [REG_WIDTH-1:0]  lsb_din,
    output logic                  lsb_done,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] IF_RD = 3'd1;
    localparam logic [2:0] LS_RD = 3'd2;
    localparam logic [2:0] LS_WR = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]            state;
    logic                  last_grant;
    logic                  owner_if;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic [2:0]            nbytes;
    logic [2:0]            cnt;
    logic                  pend;
    logic [1:0]            pend_idx;
    logic [REG_WIDTH-1:0]  rd_buf;
    logic [REG_WIDTH-1:0]  rd_word;
    logic                  grant_lsb;
    logic                  issuing;
    logic                  io_stall;

`ifdef IO_STALL_EN
    assign io_stall = io_buffer_full &&
                      (addr == ADDR_WIDTH'(32'h30000) || addr == ADDR_WIDTH'(32'h30004));
`else
    logic unused_io;
    assign unused_io = io_buffer_full;
    assign io_stall  = 1'b0;
`endif

    // last_grant high means the LSB won the previous arbitration
    assign grant_lsb = lsb_signal && (!if_signal || !last_grant);
    assign issuing   = ((state == IF_RD || state == LS_RD) && cnt < nbytes) || state == LS_WR;
    assign mem_a     = issuing ? addr + ADDR_WIDTH'(cnt) : '0;
    assign mem_wr    = state == LS_WR && rdy_in && !io_stall;
    assign mem_dout  = state == LS_WR ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'h00;

    // pend marks a byte addressed last cycle with rdy_in high; it lands on mem_din now
    always_comb begin
        rd_word = rd_buf;
        if (pend) rd_word[{pend_idx, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            owner_if   <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            nbytes     <= '0;
            cnt        <= '0;
            pend       <= 1'b0;
            pend_idx   <= '0;
            rd_buf     <= '0;
            if_data    <= '0;
            if_done    <= 1'b0;
            lsb_din    <= '0;
            lsb_done   <= 1'b0;
        end else begin
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            pend     <= 1'b0;
            rd_buf   <= rd_word;
            case (state)
                IDLE: if (rdy_in && !clear_signal && (if_signal || lsb_signal)) begin
                    cnt        <= '0;
                    rd_buf     <= '0;
                    last_grant <= grant_lsb;
                    owner_if   <= !grant_lsb;
                    addr       <= grant_lsb ? lsb_addr : if_addr;
                    wdata      <= lsb_dout[31:0];
                    nbytes     <= !grant_lsb ? 3'd4 : lsb_len == 2'd0 ? 3'd1 : lsb_len == 2'd1 ? 3'd2 : 3'd4;
                    state      <= !grant_lsb ? IF_RD : lsb_wr ? LS_WR : LS_RD;
                end
                IF_RD, LS_RD: if (clear_signal) begin
                    state <= IDLE;
                end else if (rdy_in) begin
                    if (cnt < nbytes) begin
                        cnt      <= cnt + 3'd1;
                        pend     <= 1'b1;
                        pend_idx <= cnt[1:0];
                    end else begin
                        state <= DONE;
                        if (owner_if) begin
                            if_data <= rd_word;
                            if_done <= 1'b1;
                        end else begin
                            lsb_din  <= rd_word;
                            lsb_done <= 1'b1;
                        end
                    end
                end
                // committed stores ignore clear_signal
                LS_WR: if (rdy_in && !io_stall) begin
                    if (cnt == nbytes - 3'd1) begin
                        state    <= DONE;
                        lsb_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                DONE: if (rdy_in) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven vectors plus scoreboard queues for mem_arbiter, with a byte RAM model.
module tb_mem_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        clear_signal = 1'b0;
    logic        if_signal = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_data;
    logic        if_done;
    logic        lsb_signal = 1'b0;
    logic        lsb_wr = 1'b0;
    logic [1:0]  lsb_len = '0;
    logic [31:0] lsb_addr = '0;
    logic [31:0] lsb_dout = '0;
    logic [31:0] lsb_din;
    logic        lsb_done;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    mem_arbiter dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
        .if_signal(if_signal), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .lsb_signal(lsb_signal), .lsb_wr(lsb_wr), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
        .lsb_dout(lsb_dout), .lsb_din(lsb_din), .lsb_done(lsb_done),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        is_if;
        logic        wr;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] data;
        int          lo_from;
        int          lo_to;
        int          clr_at;
        int          io_to;
        logic [31:0] exp_data;
        int          exp_cyc;
    } vec_t;
    typedef struct { logic st; logic [31:0] d; } lx_t;
    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;

`ifdef IO_STALL_EN
    localparam int IO_CYC = 6;
`else
    localparam int IO_CYC = 2;
`endif

    logic [7:0]  ram [0:1023];
    logic [31:0] q_if[$];
    lx_t         q_lsb[$];
    wr_t         q_wr[$];
    logic        order[$];
    int          errors = 0;
    int          checks = 0;
    vec_t        tbl [17];

    // byte RAM: registered read, data one cycle after the address
    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
        mem_din <= ram[mem_a[9:0]];
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk_in) begin : mon
        lx_t e;
        wr_t w;
        if (rst_n_in) begin
            if (if_done) begin
                if (q_if.size() == 0) chk("if_done_unexpected", {31'd0, if_done}, 32'd0);
                else chk("if_data", if_data, q_if.pop_front());
            end
            if (lsb_done) begin
                if (q_lsb.size() == 0) chk("lsb_done_unexpected", {31'd0, lsb_done}, 32'd0);
                else begin
                    e = q_lsb.pop_front();
                    if (!e.st) chk("lsb_din", lsb_din, e.d);
                end
            end
            if (mem_wr) begin
                if (q_wr.size() == 0) chk("mem_wr_unexpected", {31'd0, mem_wr}, 32'd0);
                else begin
                    w = q_wr.pop_front();
                    chk("wr_addr", mem_a, w.a);
                    chk("wr_data", {24'd0, mem_dout}, {24'd0, w.d});
                end
            end
        end
    end

    task automatic do_req(input string name, input vec_t v);
        int   k;
        int   n;
        logic done;
        n = (v.is_if || v.len[1]) ? 4 : v.len == 2'd1 ? 2 : 1;
        if (v.is_if) q_if.push_back(v.exp_data);
        else q_lsb.push_back('{st: v.wr, d: v.exp_data});
        if (!v.is_if && v.wr)
            for (int i = 0; i < n; i++) q_wr.push_back('{a: v.addr + 32'(i), d: 8'(v.data >> (8 * i))});
        @(posedge clk_in); #1;
        io_buffer_full = v.io_to > 0;
        if (v.is_if) begin
            if_addr = v.addr; if_signal = 1'b1;
        end else begin
            lsb_wr = v.wr; lsb_len = v.len; lsb_addr = v.addr; lsb_dout = v.data; lsb_signal = 1'b1;
        end
        k = 0;
        done = 1'b0;
        while (!done && k < 40) begin
            @(posedge clk_in); #1;
            k++;
            rdy_in = !(k >= v.lo_from && k <= v.lo_to);
            clear_signal = (k == v.clr_at);
            io_buffer_full = k < v.io_to;
            @(negedge clk_in);
            if (!rdy_in) chk("wr_when_paused", {31'd0, mem_wr}, 32'd0);
`ifdef IO_STALL_EN
            if (io_buffer_full && !v.is_if && v.wr && (v.addr == 32'h30000 || v.addr == 32'h30004))
                chk("wr_when_io_full", {31'd0, mem_wr}, 32'd0);
`endif
            done = v.is_if ? if_done : lsb_done;
        end
        if_signal = 1'b0;
        lsb_signal = 1'b0;
        chk({name, "_latency"}, 32'(k), 32'(v.exp_cyc));
        @(posedge clk_in); #1;
        rdy_in = 1'b1; clear_signal = 1'b0; io_buffer_full = 1'b0;
        @(negedge clk_in);
        chk({name, "_done_one_cycle"}, {30'd0, if_done, lsb_done}, 32'd0);
    endtask

    task automatic req_loop(input logic is_if, input int n);
        int c;
        for (int t = 0; t < n; t++) begin
            if (is_if) begin
                q_if.push_back(32'h00000513); if_addr = 32'h100; if_signal = 1'b1;
            end else begin
                q_lsb.push_back('{st: 1'b0, d: 32'h44332211});
                lsb_wr = 1'b0; lsb_len = 2'd2; lsb_addr = 32'h180; lsb_signal = 1'b1;
            end
            c = 0;
            do begin
                @(negedge clk_in);
                c++;
            end while (!(is_if ? if_done : lsb_done) && c < 60);
            if (c >= 60) chk(is_if ? "arb_if_timeout" : "arb_lsb_timeout", 32'(c), 32'd0);
            order.push_back(is_if);
            if (is_if) if_signal = 1'b0; else lsb_signal = 1'b0;
            @(negedge clk_in);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic dn, wr;
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h13; ram[10'h101] = 8'h05;
        ram[10'h180] = 8'h11; ram[10'h181] = 8'h22; ram[10'h182] = 8'h33; ram[10'h183] = 8'h44;
        ram[10'h3FF] = 8'hAB; ram[10'h000] = 8'hCD; ram[10'h001] = 8'h01; ram[10'h002] = 8'h02;
        //         is_if wr    len    addr           data           lo_f lo_t clr io  exp_data       cyc
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0100, 32'h0,          0, -1, -1, 0, 32'h0000_0513, 6};
        tbl[1]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0200, 32'hA1B2_C3D4,  0, -1, -1, 0, 32'h0,         3};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0180, 32'h0,          0, -1, -1, 0, 32'h0000_0011, 3};
        tbl[3]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0181, 32'h0,          0, -1, -1, 0, 32'h0000_3322, 4};
        tbl[4]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0180, 32'h0,          0, -1, -1, 0, 32'h4433_2211, 6};
        tbl[5]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0180, 32'h0,          0, -1, -1, 0, 32'h4433_2211, 6};
        tbl[6]  = '{1'b0, 1'b1, 2'd2, 32'h0000_0204, 32'hDEAD_BEEF,  0, -1, -1, 0, 32'h0,         5};
        tbl[7]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0204, 32'h0,          0, -1, -1, 0, 32'hDEAD_BEEF, 6};
        tbl[8]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0208, 32'h0000_0077,  0, -1, -1, 0, 32'h0,         2};
        tbl[9]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0208, 32'h0,          0, -1, -1, 0, 32'h0000_0077, 3};
        tbl[10] = '{1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0,          0, -1, -1, 0, 32'h0201_CDAB, 6};
        tbl[11] = '{1'b1, 1'b0, 2'd0, 32'h0000_0180, 32'h0,          2,  3, -1, 0, 32'h4433_2211, 8};
        tbl[12] = '{1'b0, 1'b1, 2'd0, 32'h0000_0240, 32'h0000_0099,  1,  1, -1, 0, 32'h0,         3};
        tbl[13] = '{1'b0, 1'b1, 2'd2, 32'h0000_0220, 32'h0102_0304,  0, -1,  2, 0, 32'h0,         5};
        tbl[14] = '{1'b0, 1'b0, 2'd2, 32'h0000_0220, 32'h0,          0, -1, -1, 0, 32'h0102_0304, 6};
        tbl[15] = '{1'b1, 1'b0, 2'd0, 32'h0000_0100, 32'h0,          5,  6, -1, 0, 32'h0000_0513, 8};
        tbl[16] = '{1'b0, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_0055,  0, -1, -1, 5, 32'h0,         IO_CYC};

        repeat (2) @(negedge clk_in);
        chk("rst_if_done", {31'd0, if_done}, 32'd0);
        chk("rst_lsb_done", {31'd0, lsb_done}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_lsb_din", lsb_din, 32'd0);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        @(negedge clk_in);

        fork
            req_loop(1'b1, 2);
            req_loop(1'b0, 2);
        join
        chk("arb_count", 32'(order.size()), 32'd4);
        if (order.size() == 4) begin
            chk("arb_order0", {31'd0, order[0]}, 32'd0);
            chk("arb_order1", {31'd0, order[1]}, 32'd1);
            chk("arb_order2", {31'd0, order[2]}, 32'd0);
            chk("arb_order3", {31'd0, order[3]}, 32'd1);
        end

        for (int i = 0; i < 17; i++) do_req($sformatf("vec%0d", i), tbl[i]);

        @(posedge clk_in); #1;
        if_addr = 32'h100; if_signal = 1'b1;
        repeat (3) begin @(posedge clk_in); #1; end
        @(negedge clk_in);
        chk("abort_pre_a", mem_a, 32'h102);
        clear_signal = 1'b1; if_signal = 1'b0;
        @(posedge clk_in); #1;
        clear_signal = 1'b0;
        @(negedge clk_in);
        chk("abort_idle_a", mem_a, 32'd0);
        dn = 1'b0; wr = 1'b0;
        repeat (8) begin @(negedge clk_in); dn |= if_done; wr |= mem_wr; end
        chk("abort_no_done", {31'd0, dn}, 32'd0);
        chk("abort_no_wr", {31'd0, wr}, 32'd0);

        @(posedge clk_in); #1;
        if_addr = 32'h100; if_signal = 1'b1;
        lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h180; lsb_signal = 1'b1;
        clear_signal = 1'b1;
        @(posedge clk_in); #1;
        if_signal = 1'b0; lsb_signal = 1'b0; clear_signal = 1'b0;
        @(negedge clk_in);
        chk("clr_idle_a", mem_a, 32'd0);
        dn = 1'b0;
        repeat (5) begin @(negedge clk_in); dn |= if_done | lsb_done; end
        chk("clr_idle_no_done", {31'd0, dn}, 32'd0);

        chk("q_if_empty", 32'(q_if.size()), 32'd0);
        chk("q_lsb_empty", 32'(q_lsb.size()), 32'd0);
        chk("q_wr_empty", 32'(q_wr.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
